// File: rtl/read_image_v2_pkg.sv
// rtl/read_image_v2_pkg.sv - shared types and constants for the 3x3 binary median scanner
package read_image_v2_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        EVAL = 3'd3,
        DONE = 3'd4
    } scanStateT;

    localparam int WIN_SIZE    = 3;
    localparam int READ_CYCLES = WIN_SIZE * WIN_SIZE;
    localparam int PIPE_DEPTH  = 2;

endpackage

// File: rtl/read_image_v2_if.sv
// rtl/read_image_v2_if.sv - pixel RAM read port: x/y address out, one data bit back
interface read_image_v2_if;
    logic [7:0] xAddressOut;
    logic [7:0] yAddressOut;
    logic       dataIn;

    modport master (output xAddressOut, output yAddressOut, input dataIn);
    modport slave  (input xAddressOut, input yAddressOut, output dataIn);
endinterface

// File: rtl/read_image_v2_image_window_scanner.sv
// rtl/read_image_v2_image_window_scanner.sv - window origin and in-window counters, pixel address generation
module read_image_v2_image_window_scanner
    import read_image_v2_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       readEn,
    input  logic       advance,
    output logic [7:0] xAddress,
    output logic [7:0] yAddress,
    output logic       readDone,
    output logic       lastWindow
);
    localparam logic [7:0] LAST_X = 8'(IMG_W - WIN_SIZE);
    localparam logic [7:0] LAST_Y = 8'(IMG_H - WIN_SIZE);
    localparam logic [1:0] LAST_C = 2'(WIN_SIZE - 1);

    logic [7:0] windowOffset;
    logic [7:0] rowIndex;
    logic [1:0] windowColCount;
    logic [1:0] windowRowCount;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            windowOffset   <= '0;
            rowIndex       <= '0;
            windowColCount <= '0;
            windowRowCount <= '0;
        end else if (clear) begin
            windowOffset   <= '0;
            rowIndex       <= '0;
            windowColCount <= '0;
            windowRowCount <= '0;
        end else begin
            if (readEn) begin
                if (windowColCount == LAST_C) begin
                    windowColCount <= '0;
                    windowRowCount <= (windowRowCount == LAST_C) ? 2'd0 : windowRowCount + 2'd1;
                end else begin
                    windowColCount <= windowColCount + 2'd1;
                end
            end
            // The final origin is kept so the address outputs stay frozen in DONE.
            if (advance && !lastWindow) begin
                if (windowOffset == LAST_X) begin
                    windowOffset <= '0;
                    rowIndex     <= rowIndex + 8'd1;
                end else begin
                    windowOffset <= windowOffset + 8'd1;
                end
            end
        end
    end

    assign xAddress   = windowOffset + {6'd0, windowColCount};
    assign yAddress   = rowIndex + {6'd0, windowRowCount};
    assign readDone   = (windowColCount == LAST_C) && (windowRowCount == LAST_C);
    assign lastWindow = (windowOffset == LAST_X) && (rowIndex == LAST_Y);

endmodule

// File: rtl/read_image_v2.sv
// rtl/read_image_v2.sv - binary 3x3 median filter engine scanning an external pixel RAM
module read_image_v2
    import read_image_v2_pkg::*;
#(
    parameter int IMG_W            = 64,
    parameter int IMG_H            = 64,
    parameter int MEDIAN_THRESHOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               init,
    read_image_v2_if.master    ram,
    output logic               medianDataOut,
    output logic [12:0]        activeWindows,
    output logic               fullImageDone
);
    scanStateT             state;
    scanStateT             nextState;
    logic                  readEn;
    logic                  waitEn;
    logic                  evalEn;
    logic                  readDone;
    logic                  lastWindow;
    logic                  waitCount;
    logic [PIPE_DEPTH-1:0] pipeValid;
    logic                  dataInSync1;
    logic [3:0]            windowSum;
    logic                  medianBit;
    logic [7:0]            xAddr;
    logic [7:0]            yAddr;

    read_image_v2_image_window_scanner #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) scanner (
        .clk        (clk),
        .reset      (reset),
        .clear      (init),
        .readEn     (readEn),
        .advance    (evalEn),
        .xAddress   (xAddr),
        .yAddress   (yAddr),
        .readDone   (readDone),
        .lastWindow (lastWindow)
    );

    assign ram.xAddressOut = xAddr;
    assign ram.yAddressOut = yAddr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (init) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    nextState = start ? READ : IDLE;
                READ:    nextState = readDone ? WAIT : READ;
                WAIT:    nextState = (waitCount == 1'(PIPE_DEPTH - 1)) ? EVAL : WAIT;
                EVAL:    nextState = lastWindow ? DONE : READ;
                DONE:    nextState = DONE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        readEn        = 1'b0;
        waitEn        = 1'b0;
        evalEn        = 1'b0;
        fullImageDone = 1'b0;
        case (state)
            READ:    readEn = 1'b1;
            WAIT:    waitEn = 1'b1;
            EVAL:    evalEn = 1'b1;
            DONE:    fullImageDone = 1'b1;
            default: ;
        endcase
    end

    assign medianBit = int'(windowSum) > MEDIAN_THRESHOLD;

    // A sample is counted as it leaves dataInSync1; the valid tag trails the READ cycle by the RAM latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipeValid     <= '0;
            dataInSync1   <= 1'b0;
            windowSum     <= '0;
            waitCount     <= 1'b0;
            medianDataOut <= 1'b0;
            activeWindows <= '0;
        end else if (init) begin
            pipeValid     <= '0;
            dataInSync1   <= 1'b0;
            windowSum     <= '0;
            waitCount     <= 1'b0;
            activeWindows <= '0;
        end else begin
            pipeValid   <= {pipeValid[PIPE_DEPTH-2:0], readEn};
            dataInSync1 <= ram.dataIn;
            waitCount   <= waitEn ? waitCount + 1'b1 : 1'b0;
            if (evalEn) begin
                medianDataOut <= medianBit;
                if (medianBit) begin
                    activeWindows <= activeWindows + 13'd1;
                end
                windowSum <= '0;
            end else if (pipeValid[PIPE_DEPTH-1] && dataInSync1) begin
                windowSum <= windowSum + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_read_image_v2.sv
// tb/tb_read_image_v2.sv - self-checking bench for read_image_v2 on 4x4, 5x4 and 64x64 images
module tb_read_image_v2;

    typedef struct {
        logic [15:0] img;
        logic [3:0]  med;
        int          act;
    } vecT;

    logic        clk = 1'b0;
    logic [2:0]  rstV;
    logic [2:0]  startV;
    logic [2:0]  initV;
    logic [2:0]  medV;
    logic [2:0]  doneV;
    logic [12:0] actA, actB, actC;
    logic        memA [16];
    logic        memB [20];
    logic        expQ [$];
    int          imgW [3] = '{4, 5, 64};
    int          nTests = 0;
    int          nFail  = 0;

    always #5 clk = ~clk;

    read_image_v2_if ramA ();
    read_image_v2_if ramB ();
    read_image_v2_if ramC ();

    read_image_v2 #(.IMG_W(4), .IMG_H(4), .MEDIAN_THRESHOLD(4)) dutA (
        .clk(clk), .reset(rstV[0]), .start(startV[0]), .init(initV[0]), .ram(ramA),
        .medianDataOut(medV[0]), .activeWindows(actA), .fullImageDone(doneV[0]));
    read_image_v2 #(.IMG_W(5), .IMG_H(4), .MEDIAN_THRESHOLD(4)) dutB (
        .clk(clk), .reset(rstV[1]), .start(startV[1]), .init(initV[1]), .ram(ramB),
        .medianDataOut(medV[1]), .activeWindows(actB), .fullImageDone(doneV[1]));
    read_image_v2 #(.IMG_W(64), .IMG_H(64), .MEDIAN_THRESHOLD(4)) dutC (
        .clk(clk), .reset(rstV[2]), .start(startV[2]), .init(initV[2]), .ram(ramC),
        .medianDataOut(medV[2]), .activeWindows(actC), .fullImageDone(doneV[2]));

    // Synchronous RAMs: data for an address appears one cycle later.
    always @(posedge clk) begin
        int ia, ib;
        ia = int'(ramA.yAddressOut) * 4 + int'(ramA.xAddressOut);
        ib = int'(ramB.yAddressOut) * 5 + int'(ramB.xAddressOut);
        ramA.dataIn <= (ia < 16) ? memA[ia] : 1'b0;
        ramB.dataIn <= (ib < 20) ? memB[ib] : 1'b0;
        ramC.dataIn <= 1'b0;
    end

    task automatic check(input string name, input int got, input int want);
        nTests++;
        if (got != want) begin
            nFail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic checkAgg(input string name, input int errs, input string detail);
        nTests++;
        if (errs != 0) begin
            nFail++;
            $display("FAIL %s: %0d bad samples, first %s", name, errs, detail);
        end
    endtask

    task automatic peek(input int which, output int x, output int y, output int med,
                        output int act, output int done);
        case (which)
            0: begin x = int'(ramA.xAddressOut); y = int'(ramA.yAddressOut); act = int'(actA); end
            1: begin x = int'(ramB.xAddressOut); y = int'(ramB.yAddressOut); act = int'(actB); end
            default: begin x = int'(ramC.xAddressOut); y = int'(ramC.yAddressOut); act = int'(actC); end
        endcase
        med  = int'(medV[which]);
        done = int'(doneV[which]);
    endtask

    // Clears the DUT with init, starts a scan and checks every cycle against expQ (one median per window).
    task automatic runScan(input int which, input string tag);
        int n, wpr, k, c, ox, oy, ex, ey, expAct, expDone;
        int x, y, med, act, done;
        int addrErr, medErr, actErr, doneErr;
        string aD, mD, cD, dD;
        n = expQ.size();
        wpr = imgW[which] - 2;
        expAct = 0;
        addrErr = 0; medErr = 0; actErr = 0; doneErr = 0;
        aD = ""; mD = ""; cD = ""; dD = "";
        @(negedge clk); initV[which] = 1'b1; startV[which] = 1'b0;
        @(posedge clk);
        @(negedge clk); initV[which] = 1'b0; startV[which] = 1'b1;
        @(posedge clk);
        @(negedge clk); startV[which] = 1'b0;
        for (int t = 0; t <= 12 * n; t++) begin
            k = t / 12;
            c = t % 12;
            peek(which, x, y, med, act, done);
            if (t < 12 * n) begin
                ox = k % wpr;
                oy = k / wpr;
                ex = (c < 9) ? ox + c % 3 : ox;
                ey = (c < 9) ? oy + c / 3 : oy;
                if (x != ex || y != ey) begin
                    if (addrErr == 0) aD = $sformatf("t=%0d got (%0d,%0d) want (%0d,%0d)", t, x, y, ex, ey);
                    addrErr++;
                end
            end
            if (t > 0 && c == 0) begin
                if (expQ[k-1]) expAct++;
                if (med != int'(expQ[k-1])) begin
                    if (medErr == 0) mD = $sformatf("window %0d got %0d want %0d", k - 1, med, expQ[k-1]);
                    medErr++;
                end
                if (act != (expAct % 8192)) begin
                    if (actErr == 0) cD = $sformatf("window %0d got %0d want %0d", k - 1, act, expAct);
                    actErr++;
                end
            end
            expDone = (t == 12 * n) ? 1 : 0;
            if (done != expDone) begin
                if (doneErr == 0) dD = $sformatf("t=%0d got %0d want %0d", t, done, expDone);
                doneErr++;
            end
            if (t < 12 * n) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        checkAgg({tag, " addr"}, addrErr, aD);
        checkAgg({tag, " median"}, medErr, mD);
        checkAgg({tag, " activeWindows"}, actErr, cD);
        checkAgg({tag, " fullImageDone"}, doneErr, dD);
        repeat (3) @(posedge clk);
        @(negedge clk);
        peek(which, x, y, med, act, done);
        check({tag, " done held"}, done, 1);
        check({tag, " active held"}, act, expAct % 8192);
    endtask

    initial begin
        vecT vecs[4];
        int x, y, med, act, done, s;
        vecs[0] = '{img: 16'hFFFF, med: 4'b1111, act: 4};
        vecs[1] = '{img: 16'h0000, med: 4'b0000, act: 0};
        vecs[2] = '{img: 16'h0017, med: 4'b0000, act: 0};
        vecs[3] = '{img: 16'h0037, med: 4'b0001, act: 1};
        for (int p = 0; p < 16; p++) memA[p] = 1'b0;
        for (int p = 0; p < 20; p++) memB[p] = 1'b0;
        rstV = 3'b000; startV = 3'b000; initV = 3'b000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            peek(w, x, y, med, act, done);
            check($sformatf("reset dut%0d outputs", w), x + y + med + act + done, 0);
        end
        rstV = 3'b111;

        // Table vectors on the 4x4 engine, including the 4-vs-5 ones threshold boundary.
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 16; p++) memA[p] = vecs[i].img[p];
            expQ = {};
            for (int k = 0; k < 4; k++) expQ.push_back(vecs[i].med[k]);
            runScan(0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d final active", i), int'(actA), vecs[i].act);
        end

        // init pulse in DONE with start held high restarts cleanly.
        for (int p = 0; p < 16; p++) memA[p] = 1'b1;
        expQ = {};
        for (int k = 0; k < 4; k++) expQ.push_back(1'b1);
        runScan(0, "ones base");
        @(negedge clk); initV[0] = 1'b1; startV[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("init clears active", int'(actA), 0);
        check("init clears done", int'(doneV[0]), 0);
        initV[0] = 1'b0;
        @(posedge clk);
        @(negedge clk); startV[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("restart second x address", int'(ramA.xAddressOut), 1);
        runScan(0, "ones rerun");

        // Asynchronous reset mid-READ on the 5x4 engine.
        for (int p = 0; p < 20; p++) memB[p] = 1'b1;
        @(negedge clk); initV[1] = 1'b1;
        @(posedge clk);
        @(negedge clk); initV[1] = 1'b0; startV[1] = 1'b1;
        @(posedge clk);
        @(negedge clk); startV[1] = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("pre-reset active", int'(actB), 1);
        check("pre-reset y address", int'(ramB.yAddressOut), 1);
        rstV[1] = 1'b0;
        #1;
        peek(1, x, y, med, act, done);
        check("mid-read reset addr", x + y, 0);
        check("mid-read reset median", med, 0);
        check("mid-read reset active", act, 0);
        check("mid-read reset done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rstV[1] = 1'b1;

        // Random images on 5x4 against a window-sum reference model.
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 20; p++) memB[p] = 1'($urandom_range(0, 1));
            expQ = {};
            for (int k = 0; k < 6; k++) begin
                s = 0;
                for (int dy = 0; dy < 3; dy++)
                    for (int dx = 0; dx < 3; dx++)
                        s += int'(memB[(k / 3 + dy) * 5 + (k % 3) + dx]);
                expQ.push_back(s > 4);
            end
            runScan(1, $sformatf("rand%0d", r));
        end

        // Full-size all-zero image.
        expQ = {};
        for (int k = 0; k < 62 * 62; k++) expQ.push_back(1'b0);
        runScan(2, "zeros64");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
